dvp_frame_packer: RTL and testbench
===================================

# dvp_frame_packer

Parametrised DVP frame capture and packing block for the camera path of `cnn_top`. It samples a camera byte stream (OV7725-style href/vsync/data), assembles bytes into pixels and pixels into bus-width words, and presents them on a valid/ready stream to the frame FIFO. It checks line and frame geometry, counts frames, and raises a level interrupt per completed frame, which software clears through the register block. Camera inputs arrive already synchronised into the `clk` domain, with a one-cycle sample strobe.

## Interface
- `DATA_W`, 8: camera byte width.
- `BPP`, 2: bytes per pixel (2 = RGB565, 1 = mono).
- `PACK_W`, 64: output word width; must be a multiple of `DATA_W`.
- `H_ACT`, 640: active pixels per line.
- `V_ACT`, 480: active lines per frame.
- `VS_POL`, 1: vsync active level; 1 = high during blanking.
- Constraint: `H_ACT*BPP*DATA_W % PACK_W == 0`; violations are caught by an elaboration-time assertion.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `i_enable` in 1: capture enable; sampled only at frame boundaries.
- `i_pix_en` in 1: one-cycle sample strobe.
- `i_data` in `DATA_W`: camera byte.
- `i_href` in 1: line valid.
- `i_vsync` in 1: frame sync.
- `o_wdata` out `PACK_W`: packed word; first byte sits at the LSBs.
- `o_wvalid` out 1: word valid.
- `i_wready` in 1: sink ready.
- `o_wlast` out 1: marks the last word of the frame.
- `o_interrupt` out 1: frame-done interrupt, level.
- `i_int_clr` in 1: one-cycle clear pulse.
- `o_status` out 3: sticky flags {line_err, overflow, frame_done}.
- `o_frame_cnt` out 16: completed frames; wraps at 0xFFFF→0.

## Operation
State machine states: IDLE, WAIT_VS, ACTIVE, FLUSH.
- IDLE: go to WAIT_VS when `i_enable`=1.
- WAIT_VS: go to ACTIVE on the sampled vsync transition from active to inactive (this is frame start). Clear the byte, pixel and line counters.
- ACTIVE:
  - Accept a byte only when `i_pix_en && i_href`.
  - Shift the byte into the pack register at offset `byte_cnt*DATA_W`.
  - When `PACK_W/DATA_W` bytes are collected, form a word.
- ACTIVE, on `i_href` falling (sampled on `i_pix_en`):
  - If the line's byte count ≠ `H_ACT*BPP`, set line_err.
  - Discard the partial word and increment the line count.
- ACTIVE → FLUSH: after the `V_ACT`-th line completes. The last word of that line carries `o_wlast`=1.
- ACTIVE → FLUSH early: if vsync goes active before `V_ACT` lines, set line_err. No `o_wlast` is emitted.
- FLUSH: wait until the output register is empty (last word accepted). Then:
  - set frame_done;
  - assert `o_interrupt`;
  - increment `o_frame_cnt`;
  - return to WAIT_VS if `i_enable`=1, else IDLE.
- `i_enable` deasserted mid-frame: the current frame completes normally.

Output register (single entry, no skid):
- If a new word completes while `o_wvalid && !i_wready`, drop the new word and set overflow.
- The held word is kept unchanged.

Interrupt and status:
- `o_interrupt` = frame_done.
- `i_int_clr` clears all three sticky flags.
- If a set and `i_int_clr` occur in the same cycle, the set wins.

## Timing
- Reset: state IDLE; all outputs 0; all counters and flags 0.
- Latency: `o_wvalid` rises 1 cycle after the `i_pix_en` that completes a word.
- Handshake:
  - A word transfers when `o_wvalid && i_wready`.
  - `o_wdata` and `o_wlast` are stable while `o_wvalid && !i_wready`.
  - `o_wvalid` never drops without a transfer.
- `o_interrupt` rises 1 cycle after the `o_wlast` transfer cycle.
- `o_interrupt` falls 1 cycle after `i_int_clr`, unless a set occurs in that same cycle.
- A back-to-back word every cycle is supported when `i_wready`=1 and `PACK_W == DATA_W`.
- Asynchronous reset mid-frame: immediate return to IDLE, no partial word output. The next capture waits for a fresh vsync edge.

## Structure
- Shared package `cnn_cam_pkg`:
  - state typedef `cam_st_e`;
  - status bit indices `ST_FDONE=0`, `ST_OVF=1`, `ST_LERR=2`;
  - frame counter width constant.
- Sub-module `pix_word_packer`: byte→word shift/pack register with a byte counter, plus the single-entry output register and valid/ready logic.
- The top level holds the FSM, geometry counters, sync edge detect, status and interrupt logic.

## Test plan
Common parameters: `DATA_W`=8, `BPP`=2, `PACK_W`=32, `H_ACT`=4, `V_ACT`=2.
- **Nominal frame:** bytes 0x00..0x0F over 2 lines, `i_wready`=1. Expect 4 words: 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C. `o_wlast` on the 4th word; `o_interrupt`=1 the next cycle; `o_frame_cnt`=1.
- **Backpressure:** same frame, `i_wready`=0 for 6 cycles after word 1 is presented. Word 1 stays held; word 2 is dropped; overflow=1; `o_wdata` stays stable throughout.
- **Short line:** line 1 has 6 bytes. Expect line_err=1 at href fall and 3 words total; frame_done is still set.
- **Clear race:** `i_int_clr` pulses in the same cycle that frame_done sets. Expect `o_interrupt` to remain 1. A second clear alone drops it 1 cycle later.
- **Mid-frame reset:** assert `rst_n`=0 after 5 bytes. All outputs are 0 immediately. After release, capture starts only after the next vsync edge; `o_frame_cnt` restarts at 0.
- **Early vsync and disable:** vsync goes active after 1 line → line_err=1, no `o_wlast`. `i_enable`=0 mid-frame → FSM ends in IDLE after FLUSH.

Source files
------------

// File: rtl/dvp_frame_packer_pkg.sv
// Shared camera-path types: capture FSM states, status bit positions and counter widths.
package cnn_cam_pkg;

    typedef enum logic [1:0] {
        CAM_IDLE    = 2'd0,
        CAM_WAIT_VS = 2'd1,
        CAM_ACTIVE  = 2'd2,
        CAM_FLUSH   = 2'd3
    } cam_st_e;

    localparam int unsigned ST_FDONE    = 0;
    localparam int unsigned ST_OVF      = 1;
    localparam int unsigned ST_LERR     = 2;
    localparam int unsigned STATUS_W    = 3;
    localparam int unsigned FRAME_CNT_W = 16;

endpackage

// File: rtl/dvp_frame_packer_if.sv
// Packed-word valid/ready stream from the frame packer to the frame FIFO.
interface dvp_frame_packer_if #(
    parameter int unsigned PACK_W = 64
) ();

    logic [PACK_W-1:0] wdata;
    logic              wvalid;
    logic              wready;
    logic              wlast;

    modport master (output wdata, output wvalid, output wlast, input wready);
    modport slave  (input wdata, input wvalid, input wlast, output wready);

endinterface

// File: rtl/pix_word_packer.sv
// Byte-to-word pack register plus a single-entry output register on a valid/ready stream.
module pix_word_packer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned PACK_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              byte_vld_i,
    input  logic              clr_i,
    input  logic              last_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ovf_c,
    dvp_frame_packer_if.master wr
);

    localparam int unsigned NB  = PACK_W / DATA_W;
    localparam int unsigned BCW = (NB > 1) ? $clog2(NB) : 1;

    logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
    logic [PACK_W-1:0] pack_q, pack_d;
    logic [PACK_W-1:0] wdata_q, wdata_d;
    logic              wvalid_q, wvalid_d;
    logic              wlast_q, wlast_d;
    logic              word_done_c;
    logic [31:0]       sh_c;

    always_comb begin
        byte_cnt_d  = byte_cnt_q;
        pack_d      = pack_q;
        wdata_d     = wdata_q;
        wvalid_d    = wvalid_q;
        wlast_d     = wlast_q;
        word_done_c = 1'b0;
        ovf_c       = 1'b0;
        sh_c        = 32'(byte_cnt_q) * 32'(DATA_W);

        if (wvalid_q && wr.wready) begin
            wvalid_d = 1'b0;
            wlast_d  = 1'b0;
        end

        // Byte lands in its lane; the lane is overwritten so stale bytes never leak
        if (clr_i) begin
            byte_cnt_d = '0;
        end else if (byte_vld_i) begin
            pack_d = (pack_q & ~(PACK_W'({DATA_W{1'b1}}) << sh_c)) | (PACK_W'(data_i) << sh_c);
            if (byte_cnt_q == BCW'(NB - 1)) begin
                byte_cnt_d  = '0;
                word_done_c = 1'b1;
            end else begin
                byte_cnt_d = byte_cnt_q + BCW'(1);
            end
        end

        // A held, unaccepted word wins; the new word is dropped
        if (word_done_c) begin
            if (wvalid_q && !wr.wready) begin
                ovf_c = 1'b1;
            end else begin
                wdata_d  = pack_d;
                wvalid_d = 1'b1;
                wlast_d  = last_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt_q <= '0;
            pack_q     <= '0;
            wdata_q    <= '0;
            wvalid_q   <= 1'b0;
            wlast_q    <= 1'b0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            pack_q     <= pack_d;
            wdata_q    <= wdata_d;
            wvalid_q   <= wvalid_d;
            wlast_q    <= wlast_d;
        end
    end

    assign wr.wdata  = wdata_q;
    assign wr.wvalid = wvalid_q;
    assign wr.wlast  = wlast_q;

endmodule

// File: rtl/dvp_frame_packer.sv
// DVP frame capture: sync edge detect, geometry checks, frame FSM, sticky status and interrupt.
module dvp_frame_packer
    import cnn_cam_pkg::*;
#(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned BPP    = 2,
    parameter int unsigned PACK_W = 64,
    parameter int unsigned H_ACT  = 640,
    parameter int unsigned V_ACT  = 480,
    parameter bit          VS_POL = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_enable,
    input  logic                   i_pix_en,
    input  logic [DATA_W-1:0]      i_data,
    input  logic                   i_href,
    input  logic                   i_vsync,
    dvp_frame_packer_if.master     wr,
    output logic                   o_interrupt,
    input  logic                   i_int_clr,
    output logic [STATUS_W-1:0]    o_status,
    output logic [FRAME_CNT_W-1:0] o_frame_cnt
);

    localparam int unsigned LINE_BYTES = H_ACT * BPP;
    localparam int unsigned LBW        = $clog2(LINE_BYTES + 2);
    localparam int unsigned LCW        = $clog2(V_ACT + 1);

    if (((H_ACT * BPP * DATA_W) % PACK_W != 0) || (PACK_W % DATA_W != 0)) begin : g_geom_chk
        $error("dvp_frame_packer: line length must be a whole number of PACK_W words");
    end

    cam_st_e                state_q;
    logic                   vs_act_prev_q, href_prev_q, wlast_seen_q;
    logic [LBW-1:0]         line_bytes_q;
    logic [LCW-1:0]         line_cnt_q;
    logic [STATUS_W-1:0]    status_q, status_d, set_c;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;

    logic vs_act_c, vs_start_c, vs_rise_c, href_fall_c, byte_acc_c;
    logic last_c, pk_clr_c, ovf_c, xfer_c, done_c, lerr_c;

    assign vs_act_c    = (i_vsync == VS_POL);
    assign vs_start_c  = i_pix_en && vs_act_prev_q && !vs_act_c;
    assign vs_rise_c   = i_pix_en && !vs_act_prev_q && vs_act_c;
    assign href_fall_c = i_pix_en && href_prev_q && !i_href;
    assign byte_acc_c  = (state_q == CAM_ACTIVE) && i_pix_en && i_href;
    assign last_c      = (line_cnt_q == LCW'(V_ACT - 1)) && (line_bytes_q == LBW'(LINE_BYTES - 1));
    assign pk_clr_c    = (state_q != CAM_ACTIVE) || href_fall_c;
    assign xfer_c      = wr.wvalid && wr.wready;

    // Frame completes on the wlast handshake, or on draining a frame that never produced one
    assign done_c   = (xfer_c && wr.wlast) ||
                      ((state_q == CAM_FLUSH) && !wr.wvalid && !wlast_seen_q);
    assign lerr_c   = (state_q == CAM_ACTIVE) &&
                      (vs_rise_c || (href_fall_c && (line_bytes_q != LBW'(LINE_BYTES))));
    assign set_c    = {lerr_c, ovf_c, done_c};
    assign status_d = (status_q & ~{STATUS_W{i_int_clr}}) | set_c;

    pix_word_packer #(
        .DATA_W (DATA_W),
        .PACK_W (PACK_W)
    ) u_pack (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_vld_i (byte_acc_c),
        .clr_i      (pk_clr_c),
        .last_i     (last_c),
        .data_i     (i_data),
        .ovf_c      (ovf_c),
        .wr         (wr)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= CAM_IDLE;
            vs_act_prev_q <= 1'b0;
            href_prev_q   <= 1'b0;
            wlast_seen_q  <= 1'b0;
            line_bytes_q  <= '0;
            line_cnt_q    <= '0;
            status_q      <= '0;
            frame_cnt_q   <= '0;
        end else begin
            if (i_pix_en) begin
                vs_act_prev_q <= vs_act_c;
                href_prev_q   <= i_href;
            end
            status_q <= status_d;
            if (done_c) frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
            if (xfer_c && wr.wlast) wlast_seen_q <= 1'b1;

            case (state_q)
                CAM_IDLE: begin
                    if (i_enable) state_q <= CAM_WAIT_VS;
                end
                CAM_WAIT_VS: begin
                    if (vs_start_c) begin
                        line_bytes_q <= '0;
                        line_cnt_q   <= '0;
                        wlast_seen_q <= 1'b0;
                        state_q      <= CAM_ACTIVE;
                    end
                end
                CAM_ACTIVE: begin
                    if (byte_acc_c && (line_bytes_q != LBW'(LINE_BYTES + 1)))
                        line_bytes_q <= line_bytes_q + LBW'(1);
                    if (vs_rise_c) begin
                        state_q <= CAM_FLUSH;
                    end else if (href_fall_c) begin
                        line_bytes_q <= '0;
                        line_cnt_q   <= line_cnt_q + LCW'(1);
                        if (line_cnt_q == LCW'(V_ACT - 1)) state_q <= CAM_FLUSH;
                    end
                end
                CAM_FLUSH: begin
                    if (!wr.wvalid) state_q <= i_enable ? CAM_WAIT_VS : CAM_IDLE;
                end
                default: state_q <= CAM_IDLE;
            endcase
        end
    end

    assign o_interrupt = status_q[ST_FDONE];
    assign o_status    = status_q;
    assign o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_dvp_frame_packer.sv
// Directed bench for dvp_frame_packer: 4-pixel x 2-line RGB565 frames packed into 32-bit words.
module tb_dvp_frame_packer;
    import cnn_cam_pkg::*;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned BPP    = 2;
    localparam int unsigned PACK_W = 32;
    localparam int unsigned H_ACT  = 4;
    localparam int unsigned V_ACT  = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   i_enable = 1'b0;
    logic                   i_pix_en = 1'b0;
    logic [DATA_W-1:0]      i_data = '0;
    logic                   i_href = 1'b0;
    logic                   i_vsync = 1'b0;
    logic                   i_int_clr = 1'b0;
    logic                   o_interrupt;
    logic [STATUS_W-1:0]    o_status;
    logic [FRAME_CNT_W-1:0] o_frame_cnt;

    dvp_frame_packer_if #(.PACK_W(PACK_W)) wr ();

    dvp_frame_packer #(
        .DATA_W (DATA_W),
        .BPP    (BPP),
        .PACK_W (PACK_W),
        .H_ACT  (H_ACT),
        .V_ACT  (V_ACT),
        .VS_POL (1'b1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_enable    (i_enable),
        .i_pix_en    (i_pix_en),
        .i_data      (i_data),
        .i_href      (i_href),
        .i_vsync     (i_vsync),
        .wr          (wr),
        .o_interrupt (o_interrupt),
        .i_int_clr   (i_int_clr),
        .o_status    (o_status),
        .o_frame_cnt (o_frame_cnt)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Transfer log, sampled mid-cycle: wready is only changed just after a rising edge
    logic [PACK_W-1:0] wq[$];
    bit                lq[$];
    logic [PACK_W-1:0] exp_q[$];
    int                wlast_cyc = -1;
    int                irq_cyc   = -1;
    logic              irq_prev  = 1'b0;

    always @(negedge clk) begin
        if (wr.wvalid && wr.wready) begin
            wq.push_back(wr.wdata);
            lq.push_back(wr.wlast);
            if (wr.wlast) wlast_cyc = cyc;
        end
        if (o_interrupt && !irq_prev) irq_cyc = cyc;
        irq_prev = o_interrupt;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] word_at(input int i);
        if (i < wq.size()) return 64'(wq[i]);
        return 64'hBAD0_BAD0_BAD0_BAD0;
    endfunction

    function automatic logic [63:0] last_at(input int i);
        if (i < lq.size()) return 64'(lq[i]);
        return 64'd2;
    endfunction

    task automatic check_frame(input string tag, input int last_idx);
        check({tag, "_nwords"}, 64'(wq.size()), 64'(exp_q.size()));
        foreach (exp_q[i]) begin
            check({tag, "_word"}, word_at(i), 64'(exp_q[i]));
            check({tag, "_last"}, last_at(i), 64'(i == last_idx));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cam(input logic href, input logic vs, input logic [DATA_W-1:0] d);
        i_pix_en = 1'b1;
        i_href   = href;
        i_vsync  = vs;
        i_data   = d;
        tick();
    endtask

    task automatic vs_pulse();
        cam(1'b0, 1'b1, '0);
        cam(1'b0, 1'b1, '0);
        cam(1'b0, 1'b0, '0);
        cam(1'b0, 1'b0, '0);
    endtask

    task automatic send_line(input int n, input logic [DATA_W-1:0] base, input bit clr_on_fall);
        for (int i = 0; i < n; i++) cam(1'b1, 1'b0, DATA_W'(32'(base) + i));
        i_int_clr = clr_on_fall;
        cam(1'b0, 1'b0, '0);
        i_int_clr = 1'b0;
        cam(1'b0, 1'b0, '0);
    endtask

    task automatic clear_log();
        wq.delete();
        lq.delete();
        exp_q.delete();
        wlast_cyc = -1;
        irq_cyc   = -1;
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        i_pix_en  = 1'b0;
        i_href    = 1'b0;
        i_vsync   = 1'b0;
        i_int_clr = 1'b0;
        i_enable  = 1'b0;
        wr.wready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        clear_log();
    endtask

    // Holds wready low for 6 cycles once the first word appears, checking it never moves
    task automatic stall_watch();
        int                k = 0;
        bit                stable = 1'b1;
        logic [PACK_W-1:0] held;
        while (!wr.wvalid && k < 40) begin
            tick();
            k++;
        end
        check("bp_first_word_latency", 64'(k), 64'd4);
        held = wr.wdata;
        check("bp_held_word", 64'(held), 64'h0302_0100);
        for (int i = 0; i < 6; i++) begin
            tick();
            if (wr.wdata !== held || wr.wvalid !== 1'b1 || wr.wlast !== 1'b0) stable = 1'b0;
        end
        check("bp_hold_stable", 64'(stable), 64'd1);
        wr.wready = 1'b1;
    endtask

    initial begin
        wr.wready = 1'b1;

        // Reset state
        tick();
        check("rst_wvalid", 64'(wr.wvalid), 64'd0);
        check("rst_wdata", 64'(wr.wdata), 64'd0);
        check("rst_wlast", 64'(wr.wlast), 64'd0);
        check("rst_irq", 64'(o_interrupt), 64'd0);
        check("rst_status", 64'(o_status), 64'd0);
        check("rst_fcnt", 64'(o_frame_cnt), 64'd0);

        // Nominal frame
        do_reset();
        i_enable = 1'b1;
        tick();
        vs_pulse();
        send_line(8, 8'h00, 1'b0);
        send_line(8, 8'h08, 1'b0);
        repeat (4) tick();
        exp_q = {32'h0302_0100, 32'h0706_0504, 32'h0B0A_0908, 32'h0F0E_0D0C};
        check_frame("nom", 3);
        check("nom_irq_latency", 64'(irq_cyc - wlast_cyc), 64'd1);
        check("nom_irq", 64'(o_interrupt), 64'd1);
        check("nom_status", 64'(o_status), 64'h1);
        check("nom_fcnt", 64'(o_frame_cnt), 64'd1);

        // Backpressure: word 2 arrives while word 1 is still held
        do_reset();
        i_enable = 1'b1;
        tick();
        vs_pulse();
        wr.wready = 1'b0;
        fork
            begin
                send_line(8, 8'h00, 1'b0);
                send_line(8, 8'h08, 1'b0);
            end
            stall_watch();
        join
        repeat (4) tick();
        exp_q = {32'h0302_0100, 32'h0B0A_0908, 32'h0F0E_0D0C};
        check_frame("bp", 2);
        check("bp_status", 64'(o_status), 64'h3);
        check("bp_fcnt", 64'(o_frame_cnt), 64'd1);

        // Short first line
        do_reset();
        i_enable = 1'b1;
        tick();
        vs_pulse();
        send_line(6, 8'h00, 1'b0);
        check("sl_lerr_at_fall", 64'(o_status), 64'h4);
        send_line(8, 8'h10, 1'b0);
        repeat (4) tick();
        exp_q = {32'h0302_0100, 32'h1312_1110, 32'h1716_1514};
        check_frame("sl", 2);
        check("sl_status", 64'(o_status), 64'h5);
        check("sl_fcnt", 64'(o_frame_cnt), 64'd1);

        // Clear pulse coincides with frame_done set
        do_reset();
        i_enable = 1'b1;
        tick();
        vs_pulse();
        send_line(8, 8'h00, 1'b0);
        send_line(8, 8'h08, 1'b1);
        check("cr_irq_held", 64'(o_interrupt), 64'd1);
        check("cr_status_held", 64'(o_status), 64'h1);
        repeat (2) tick();
        i_int_clr = 1'b1;
        tick();
        i_int_clr = 1'b0;
        check("cr_irq_cleared", 64'(o_interrupt), 64'd0);
        check("cr_status_cleared", 64'(o_status), 64'h0);
        check("cr_fcnt", 64'(o_frame_cnt), 64'd1);

        // Mid-frame reset with a word held in the output register
        wr.wready = 1'b0;
        vs_pulse();
        for (int i = 0; i < 5; i++) cam(1'b1, 1'b0, DATA_W'(i));
        check("mr_pre_wvalid", 64'(wr.wvalid), 64'd1);
        check("mr_pre_fcnt", 64'(o_frame_cnt), 64'd1);
        rst_n = 1'b0;
        #1;
        check("mr_wvalid", 64'(wr.wvalid), 64'd0);
        check("mr_wdata", 64'(wr.wdata), 64'd0);
        check("mr_wlast", 64'(wr.wlast), 64'd0);
        check("mr_irq", 64'(o_interrupt), 64'd0);
        check("mr_status", 64'(o_status), 64'd0);
        check("mr_fcnt", 64'(o_frame_cnt), 64'd0);
        i_pix_en = 1'b0;
        i_href   = 1'b0;
        tick();
        rst_n     = 1'b1;
        wr.wready = 1'b1;
        tick();
        clear_log();
        send_line(8, 8'h40, 1'b0);
        repeat (2) tick();
        check("mr_no_capture_without_vsync", 64'(wq.size()), 64'd0);
        vs_pulse();
        send_line(8, 8'h00, 1'b0);
        send_line(8, 8'h08, 1'b0);
        repeat (4) tick();
        exp_q = {32'h0302_0100, 32'h0706_0504, 32'h0B0A_0908, 32'h0F0E_0D0C};
        check_frame("mr", 3);
        check("mr_fcnt_restart", 64'(o_frame_cnt), 64'd1);

        // Early vsync after one line, enable dropped mid-frame
        do_reset();
        i_enable = 1'b1;
        tick();
        vs_pulse();
        send_line(8, 8'h00, 1'b0);
        i_enable = 1'b0;
        cam(1'b0, 1'b1, '0);
        cam(1'b0, 1'b1, '0);
        cam(1'b0, 1'b0, '0);
        repeat (3) tick();
        exp_q = {32'h0302_0100, 32'h0706_0504};
        check_frame("ev", -1);
        check("ev_status", 64'(o_status), 64'h5);
        check("ev_irq", 64'(o_interrupt), 64'd1);
        check("ev_fcnt", 64'(o_frame_cnt), 64'd1);
        vs_pulse();
        send_line(8, 8'h20, 1'b0);
        repeat (3) tick();
        check("ev_idle_no_capture", 64'(wq.size()), 64'd2);
        check("ev_idle_fcnt", 64'(o_frame_cnt), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
